// File: rtl/seg_approx_adder.sv
// Segmented ripple-carry adder, one SEG-bit segment per cycle; optional carry-free OR low region.
// Latency NSEG (exact) or 1+NSEG-NA (approx) edges after accept; result held in DONE until out_ready.
module seg_approx_adder #(
    parameter int WIDTH       = 16,
    parameter int SEG         = 4,
    parameter int APPROX_BITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             approx_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             gate_en
);

    localparam int NSEG   = WIDTH / SEG;
    localparam int NA     = APPROX_BITS / SEG;
    localparam int IDXW   = $clog2(NSEG + 1);
    localparam int AB_MSB = (APPROX_BITS > 0) ? APPROX_BITS - 1 : 0;
    localparam logic [WIDTH-1:0] AMASK =
        (APPROX_BITS == 0) ? '0 : ({WIDTH{1'b1}} >> (WIDTH - APPROX_BITS));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic            carry_q, carry_d;
    logic            approx_q, approx_d;
    logic            cout_q, cout_d;
    logic [IDXW-1:0] idx_q, idx_d;

    logic [SEG-1:0]  seg_a;
    logic [SEG-1:0]  seg_b;
    logic [SEG-1:0]  seg_s;
    logic            seg_c;
    logic            approx_carry;

    // Select the active segment of each operand by index.
    always_comb begin
        seg_a = '0;
        seg_b = '0;
        for (int k = 0; k < NSEG; k++) begin
            if (idx_q == IDXW'(k)) begin
                seg_a = a_q[k*SEG +: SEG];
                seg_b = b_q[k*SEG +: SEG];
            end
        end
        {seg_c, seg_s} = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG{1'b0}}, carry_q};
    end

    assign approx_carry = a_q[AB_MSB] & b_q[AB_MSB];

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        approx_d = approx_q;
        cout_d   = cout_q;
        idx_d    = idx_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    carry_d  = cin;
                    approx_d = approx_en && (NA != 0);
                    sum_d    = '0;
                    cout_d   = 1'b0;
                    idx_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (approx_q && (idx_q == '0)) begin
                    // Whole approximate region in one shot; the carry into the
                    // exact part is a generate from the region's top bit only.
                    sum_d   = (a_q | b_q) & AMASK;
                    carry_d = approx_carry;
                    idx_d   = IDXW'(NA);
                    if (NA == NSEG) begin
                        cout_d  = approx_carry;
                        state_d = DONE;
                    end
                end else begin
                    for (int k = 0; k < NSEG; k++) begin
                        if (idx_q == IDXW'(k)) begin
                            sum_d[k*SEG +: SEG] = seg_s;
                        end
                    end
                    carry_d = seg_c;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDXW'(NSEG - 1)) begin
                        cout_d  = seg_c;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            approx_q <= 1'b0;
            cout_q   <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            approx_q <= approx_d;
            cout_q   <= cout_d;
            idx_q    <= idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign gate_en   = (state_q == CALC);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_seg_approx_adder.sv
// Bench for seg_approx_adder (16/4/4): vector table, backpressure and reset sequences, random regression.
module tb_seg_approx_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        approx_en;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        busy;
    logic        gate_en;

    int checks = 0;
    int errors = 0;

    seg_approx_adder #(.WIDTH(16), .SEG(4), .APPROX_BITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .approx_en (approx_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy),
        .gate_en   (gate_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        ap;
        logic [15:0] exp_sum;
        logic        exp_cout;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: exact is plain addition; approx ORs the low nibble and adds
    // the upper 12 bits with a carry-in generated by bit 3.
    task automatic ref_model(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                             input logic ap, output logic [15:0] s, output logic co, output int lat);
        logic [16:0] full;
        logic [12:0] hi;
        if (ap) begin
            hi   = {1'b0, av[15:4]} + {1'b0, bv[15:4]} + {12'd0, av[3] & bv[3]};
            s    = {hi[11:0], (av[3:0] | bv[3:0])};
            co   = hi[12];
            lat  = 1 + (4 - 1);
        end else begin
            full = {1'b0, av} + {1'b0, bv} + {16'd0, cv};
            s    = full[15:0];
            co   = full[16];
            lat  = 4;
        end
    endtask

    // Called #1 after a rising edge. Leaves the DUT in DONE with out_valid sampled.
    task automatic start_and_wait(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                                  input logic ap, output int lat, output int gcnt);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        a = av; b = bv; cin = cv; approx_en = ap; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); approx_en = 1'($urandom);
        lat = 0; gcnt = 0;
        while (!out_valid && lat < 50) begin
            if (gate_en) gcnt++;
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic finish_transfer();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        int lat, gcnt;
        logic [15:0] es;
        logic        ec;
        int          el;

        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 4};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 4};
        vecs[2] = '{16'h000F, 16'h0003, 1'b0, 1'b1, 16'h000F, 1'b0, 4};
        vecs[3] = '{16'h0088, 16'h0008, 1'b0, 1'b1, 16'h0098, 1'b0, 4};
        vecs[4] = '{16'hFFFF, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 4};
        vecs[5] = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 4};
        vecs[6] = '{16'hF0F0, 16'h0F0F, 1'b1, 1'b1, 16'hFFFF, 1'b0, 4};
        vecs[7] = '{16'h8008, 16'h8008, 1'b0, 1'b1, 16'h0018, 1'b1, 4};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; approx_en = 1'b0;
        #12;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset sum", 32'(sum), 32'd0);
        check("reset cout", 32'(cout), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset gate_en", 32'(gate_en), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            start_and_wait(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].ap, lat, gcnt);
            check($sformatf("vec%0d sum", i), 32'(sum), 32'(vecs[i].exp_sum));
            check($sformatf("vec%0d cout", i), 32'(cout), 32'(vecs[i].exp_cout));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d gate_en cycles", i), 32'(gcnt), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'd1);
            finish_transfer();
            check($sformatf("vec%0d idle after transfer", i), 32'(in_ready), 32'd1);
        end

        // Backpressure: result held, no accept while in_valid toggles.
        start_and_wait(16'h1234, 16'h1111, 1'b0, 1'b0, lat, gcnt);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            a = 16'hAAAA; b = 16'h5555;
            @(posedge clk); #1;
            check("bp out_valid", 32'(out_valid), 32'd1);
            check("bp in_ready", 32'(in_ready), 32'd0);
            check("bp sum", 32'(sum), 32'h2345);
            check("bp cout", 32'(cout), 32'd0);
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("bp released in_ready", 32'(in_ready), 32'd1);
        check("bp released out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("bp no accept on DONE->IDLE", 32'(busy), 32'd0);

        // Reset in the second CALC cycle aborts without waiting for a clock edge.
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; approx_en = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre-reset gate_en", 32'(gate_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort gate_en", 32'(gate_en), 32'd0);
        check("abort sum", 32'(sum), 32'd0);
        check("abort cout", 32'(cout), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("post-abort no out_valid", 32'(out_valid), 32'd0);
        start_and_wait(16'h1234, 16'h1111, 1'b0, 1'b0, lat, gcnt);
        check("post-abort sum", 32'(sum), 32'h2345);
        check("post-abort latency", 32'(lat), 32'd4);
        finish_transfer();

        // Random regression against the reference model.
        for (int n = 0; n < 1000; n++) begin
            logic [15:0] ra, rb;
            logic rc, rp;
            int hold;
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom);  rp = 1'($urandom);
            ref_model(ra, rb, rc, rp, es, ec, el);
            start_and_wait(ra, rb, rc, rp, lat, gcnt);
            check($sformatf("rnd%0d sum a=%h b=%h c=%0d ap=%0d", n, ra, rb, rc, rp), 32'(sum), 32'(es));
            check($sformatf("rnd%0d cout", n), 32'(cout), 32'(ec));
            check($sformatf("rnd%0d latency", n), 32'(lat), 32'(el));
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
            end
            check($sformatf("rnd%0d held sum", n), 32'(sum), 32'(es));
            finish_transfer();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
